seg_display_reader: RTL and testbench

Passive monitor for the multiplexed 6-digit seven-segment bus (`segOut`/`digitSel`) that the vending machine drives. It samples the scanned segment and digit-select lines and decodes each digit back to BCD. After every digit has been captured it publishes one coherent frame with a valid pulse. It sits alongside the vending machine for on-chip self-check and bench scoreboarding, and is the receiving end of the display interface.

---
 rtl/seg_display_reader.sv | 169 ++++++++++++++++
 tb/tb_seg_display_reader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_reader.sv
// Passive receiver for the scanned 6-digit seven-segment bus: settles each digit,
// decodes it back to BCD and publishes one coherent frame once all six slots are seen.
module seg_display_reader #(
  parameter int SETTLE         = 16,
  parameter int TIMEOUT        = 2_000_000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        resetBtn_n,
  input  logic [6:0]  segIn,
  input  logic [5:0]  digitSelIn,
  output logic [23:0] digitsBcd,
  output logic [5:0]  blankMask,
  output logic        frameValid,
  output logic        frameChanged,
  output logic        segErr,
  output logic        stale
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [6:0]  seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d, seg_prev_q, seg_prev_d;
  logic [5:0]  sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d, sel_prev_q, sel_prev_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [23:0] shadow_digits_q, shadow_digits_d;
  logic [5:0]  shadow_blank_q, shadow_blank_d;
  logic [5:0]  slot_seen_q, slot_seen_d;
  logic [23:0] digits_q, digits_d;
  logic [5:0]  blank_q, blank_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_changed_q, frame_changed_d;
  logic        seg_err_q, seg_err_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic        stale_q, stale_d;

  logic [6:0]  seg_n;
  logic [5:0]  sel_n;
  logic        same, sel_any, sel_onehot, reach, capture, multi_err, frame_done;
  logic [2:0]  cap_idx;
  logic [5:0]  dec;

  // Returns {err, blank, nibble} for an active-high {g,f,e,d,c,b,a} pattern.
  function automatic logic [5:0] decode_seg(input logic [6:0] s);
    case (s)
      7'h3F:   decode_seg = 6'b00_0000;
      7'h06:   decode_seg = 6'b00_0001;
      7'h5B:   decode_seg = 6'b00_0010;
      7'h4F:   decode_seg = 6'b00_0011;
      7'h66:   decode_seg = 6'b00_0100;
      7'h6D:   decode_seg = 6'b00_0101;
      7'h7D:   decode_seg = 6'b00_0110;
      7'h07:   decode_seg = 6'b00_0111;
      7'h7F:   decode_seg = 6'b00_1000;
      7'h6F:   decode_seg = 6'b00_1001;
      7'h00:   decode_seg = 6'b01_1111;
      default: decode_seg = 6'b10_1110;
    endcase
  endfunction

  always_comb begin
    seg_s1_d   = segIn;
    seg_s2_d   = seg_s1_q;
    sel_s1_d   = digitSelIn;
    sel_s2_d   = sel_s1_q;
    seg_n      = SEG_ACTIVE_LOW ? ~seg_s2_q : seg_s2_q;
    sel_n      = SEL_ACTIVE_LOW ? ~sel_s2_q : sel_s2_q;
    seg_prev_d = seg_n;
    sel_prev_d = sel_n;

    same       = (seg_n == seg_prev_q) && (sel_n == sel_prev_q);
    sel_any    = |sel_n;
    sel_onehot = sel_any && ((sel_n & (sel_n - 6'd1)) == 6'd0);

    // One counter serves both one-hot capture and multi-hot error detection.
    if (same && sel_any) begin
      hold_d = (hold_q == CW'(SETTLE)) ? hold_q : hold_q + 1'b1;
    end else begin
      hold_d = '0;
    end
    reach     = same && sel_any && (hold_q == CW'(SETTLE - 1));
    capture   = reach && sel_onehot;
    multi_err = reach && !sel_onehot;

    cap_idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (sel_n[i]) cap_idx = 3'(i);
    end
    dec = decode_seg(seg_n);

    frame_done = (slot_seen_q == 6'h3F);

    shadow_digits_d = shadow_digits_q;
    shadow_blank_d  = shadow_blank_q;
    slot_seen_d     = frame_done ? 6'h00 : slot_seen_q;
    if (capture) begin
      shadow_digits_d[4*cap_idx +: 4] = dec[3:0];
      shadow_blank_d[cap_idx]         = dec[4];
      slot_seen_d[cap_idx]            = 1'b1;
    end

    // Publishing uses the pre-capture shadow so a same-edge capture starts the next frame.
    digits_d        = frame_done ? shadow_digits_q : digits_q;
    blank_d         = frame_done ? shadow_blank_q : blank_q;
    frame_valid_d   = frame_done;
    frame_changed_d = frame_done &&
                      ({shadow_digits_q, shadow_blank_q} != {digits_q, blank_q});

    seg_err_d = seg_err_q | multi_err | (capture & dec[5]);

    if (frame_done) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TW'(TIMEOUT)) begin
      to_cnt_d = to_cnt_q;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
    stale_d = frame_done ? 1'b0 : (stale_q | (to_cnt_d == TW'(TIMEOUT)));
  end

  always_ff @(posedge clk or negedge resetBtn_n) begin
    if (!resetBtn_n) begin
      seg_s1_q        <= '0;
      seg_s2_q        <= '0;
      seg_prev_q      <= '0;
      sel_s1_q        <= '0;
      sel_s2_q        <= '0;
      sel_prev_q      <= '0;
      hold_q          <= '0;
      shadow_digits_q <= '0;
      shadow_blank_q  <= '0;
      slot_seen_q     <= '0;
      digits_q        <= '0;
      blank_q         <= 6'h3F;
      frame_valid_q   <= 1'b0;
      frame_changed_q <= 1'b0;
      seg_err_q       <= 1'b0;
      to_cnt_q        <= '0;
      stale_q         <= 1'b1;
    end else begin
      seg_s1_q        <= seg_s1_d;
      seg_s2_q        <= seg_s2_d;
      seg_prev_q      <= seg_prev_d;
      sel_s1_q        <= sel_s1_d;
      sel_s2_q        <= sel_s2_d;
      sel_prev_q      <= sel_prev_d;
      hold_q          <= hold_d;
      shadow_digits_q <= shadow_digits_d;
      shadow_blank_q  <= shadow_blank_d;
      slot_seen_q     <= slot_seen_d;
      digits_q        <= digits_d;
      blank_q         <= blank_d;
      frame_valid_q   <= frame_valid_d;
      frame_changed_q <= frame_changed_d;
      seg_err_q       <= seg_err_d;
      to_cnt_q        <= to_cnt_d;
      stale_q         <= stale_d;
    end
  end

  assign digitsBcd    = digits_q;
  assign blankMask    = blank_q;
  assign frameValid   = frame_valid_q;
  assign frameChanged = frame_changed_q;
  assign segErr       = seg_err_q;
  assign stale        = stale_q;

endmodule

// File: tb/tb_seg_display_reader.sv
// Directed bench for seg_display_reader: scans active-low digit codes and checks
// published frames, blank/error handling, glitch rejection, resets and staleness.
module tb_seg_display_reader;

  localparam int SETTLE  = 16;
  localparam int TIMEOUT = 8000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [5:0]  sel_in;
  logic [23:0] digits_bcd;
  logic [5:0]  blank_mask;
  logic        frame_valid, frame_changed, seg_err, stale;

  int checks = 0;
  int errors = 0;
  int fv_count = 0;
  int bb_count = 0;
  int n0;
  logic last_changed = 1'b0;
  logic prev_fv = 1'b0;

  // Active-low codes: 0=40 1=79 2=24 3=30 4=19 5=12 6=02, blank=7F, a-only=7E
  localparam logic [41:0] NOMINAL = {7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h40};
  localparam logic [41:0] BLANK5  = {7'h7F, 7'h40, 7'h40, 7'h40, 7'h19, 7'h40};
  localparam logic [41:0] INVAL3  = {7'h7F, 7'h40, 7'h7E, 7'h40, 7'h19, 7'h40};
  localparam logic [41:0] SEQ     = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02};

  seg_display_reader #(
    .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .resetBtn_n(rst_n), .segIn(seg_in), .digitSelIn(sel_in),
    .digitsBcd(digits_bcd), .blankMask(blank_mask), .frameValid(frame_valid),
    .frameChanged(frame_changed), .segErr(seg_err), .stale(stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_count++;
      last_changed = frame_changed;
      if (prev_fv) bb_count++;
    end
    prev_fv = frame_valid;
  end

  task automatic drive(input logic [6:0] seg, input logic [5:0] sel, input int n);
    seg_in = seg;
    sel_in = sel;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan_digits(input logic [41:0] codes, input int hi, input int lo, input int dwell);
    for (int k = hi; k >= lo; k--) drive(codes[7*k +: 7], 6'(1 << k), dwell);
  endtask

  task automatic scan_frame(input logic [41:0] codes, input int dwell);
    scan_digits(codes, 5, 0, dwell);
    drive(7'h7F, 6'h00, 20);
  endtask

  task automatic frame_checks(input string name, input logic [23:0] exp_d, input logic [5:0] exp_b,
                              input logic exp_c);
    checks++;
    if (fv_count !== n0 + 1) begin
      errors++; $display("FAIL %s frame_count got %0d expected %0d", name, fv_count, n0 + 1);
    end
    checks++;
    if (digits_bcd !== exp_d) begin
      errors++; $display("FAIL %s digits got %h expected %h", name, digits_bcd, exp_d);
    end
    checks++;
    if (blank_mask !== exp_b) begin
      errors++; $display("FAIL %s blank got %h expected %h", name, blank_mask, exp_b);
    end
    checks++;
    if (last_changed !== exp_c) begin
      errors++; $display("FAIL %s changed got %b expected %b", name, last_changed, exp_c);
    end
    $display("frame %s: digits=%h blank=%h changed=%b err=%b stale=%b",
             name, digits_bcd, blank_mask, last_changed, seg_err, stale);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    seg_in = 7'h7F;
    sel_in = 6'h00;
    repeat (5) @(negedge clk);
    checks++;
    if (digits_bcd !== 24'h0 || blank_mask !== 6'h3F) begin
      errors++; $display("FAIL reset_frame got %h/%h expected 000000/3f", digits_bcd, blank_mask);
    end
    checks++;
    if (frame_valid !== 1'b0 || frame_changed !== 1'b0 || seg_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags got fv=%b fc=%b err=%b expected 0/0/0",
                         frame_valid, frame_changed, seg_err);
    end
    checks++;
    if (stale !== 1'b1) begin
      errors++; $display("FAIL reset_stale got %b expected 1", stale);
    end
    rst_n = 1'b1;
    drive(7'h7F, 6'h00, TIMEOUT + 100);
    checks++;
    if (stale !== 1'b1 || fv_count !== 0) begin
      errors++; $display("FAIL idle_stale got stale=%b frames=%0d expected 1/0", stale, fv_count);
    end
    $display("reset: digits=%h blank=%h stale=%b frames=%0d", digits_bcd, blank_mask, stale, fv_count);
  endtask

  task automatic test_nominal;
    n0 = fv_count;
    scan_frame(NOMINAL, 1000);
    frame_checks("nominal", 24'h000040, 6'h00, 1'b1);
    checks++;
    if (stale !== 1'b0) begin
      errors++; $display("FAIL nominal_stale got %b expected 0", stale);
    end
  endtask

  task automatic test_unchanged;
    n0 = fv_count;
    scan_frame(NOMINAL, 200);
    frame_checks("unchanged", 24'h000040, 6'h00, 1'b0);
  endtask

  task automatic test_blank_invalid;
    n0 = fv_count;
    scan_frame(BLANK5, 200);
    frame_checks("blank", 24'hF00040, 6'h20, 1'b1);
    checks++;
    if (seg_err !== 1'b0) begin
      errors++; $display("FAIL blank_err got %b expected 0", seg_err);
    end
    n0 = fv_count;
    scan_frame(INVAL3, 200);
    frame_checks("invalid", 24'hF0E040, 6'h20, 1'b1);
    checks++;
    if (seg_err !== 1'b1) begin
      errors++; $display("FAIL invalid_err got %b expected 1", seg_err);
    end
    n0 = fv_count;
    scan_frame(NOMINAL, 200);
    frame_checks("recover", 24'h000040, 6'h00, 1'b1);
    checks++;
    if (seg_err !== 1'b1) begin
      errors++; $display("FAIL sticky_err got %b expected 1", seg_err);
    end
  endtask

  task automatic test_glitch;
    n0 = fv_count;
    scan_digits(NOMINAL, 5, 1, 200);
    drive(7'h24, 6'h04, 10);
    scan_digits(NOMINAL, 0, 0, 200);
    drive(7'h7F, 6'h00, 20);
    frame_checks("glitch", 24'h000040, 6'h00, 1'b0);
  endtask

  task automatic test_multihot;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(7'h7F, 6'h00, 5);
    checks++;
    if (seg_err !== 1'b0) begin
      errors++; $display("FAIL mh_pre_err got %b expected 0", seg_err);
    end
    n0 = fv_count;
    drive(7'h40, 6'h03, 100);
    drive(7'h7F, 6'h00, 20);
    checks++;
    if (seg_err !== 1'b1 || fv_count !== n0) begin
      errors++; $display("FAIL multihot got err=%b frames=%0d expected 1/%0d", seg_err, fv_count, n0);
    end
    $display("multihot: err=%b frames=%0d", seg_err, fv_count);
  endtask

  task automatic test_reset_mid_frame;
    scan_digits(SEQ, 5, 3, 200);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n0 = fv_count;
    scan_digits(SEQ, 2, 0, 200);
    drive(7'h7F, 6'h00, 20);
    checks++;
    if (fv_count !== n0 || digits_bcd !== 24'h0) begin
      errors++; $display("FAIL midreset got frames=%0d digits=%h expected %0d/000000",
                         fv_count, digits_bcd, n0);
    end
    $display("midreset: frames=%0d digits=%h", fv_count, digits_bcd);
    scan_frame(SEQ, 200);
    frame_checks("after_reset", 24'h123456, 6'h00, 1'b1);
    checks++;
    if (stale !== 1'b0) begin
      errors++; $display("FAIL after_reset_stale got %b expected 0", stale);
    end
  endtask

  task automatic test_stale;
    drive(7'h7F, 6'h00, TIMEOUT + 100);
    checks++;
    if (stale !== 1'b1) begin
      errors++; $display("FAIL stale got %b expected 1", stale);
    end
    checks++;
    if (bb_count !== 0) begin
      errors++; $display("FAIL pulse_width got %0d back-to-back expected 0", bb_count);
    end
    $display("stale: stale=%b back_to_back=%0d", stale, bb_count);
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    test_reset;
    test_nominal;
    test_unchanged;
    test_blank_invalid;
    test_glitch;
    test_multihot;
    test_reset_mid_frame;
    test_stale;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
